uart_arbiter: RTL and testbench
===============================

UART_ARBITER -- requirements
Module: uart_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2, SHALL set the number of requester ports (2..8).
REQ-002 Parameter TIMEOUT_CYCLES, default 1024, SHALL set the maximum number of cycles spent waiting for a UART response.
REQ-003 Parameters WRITE_ADDRESS (32'h10000000) and READ_ADDRESS (32'h10000004) SHALL define the only legal addresses.
REQ-004 Ports SHALL be:
- clk_i  in  1  sole clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  NUM_REQ  per-requester request.
- we_i  in  NUM_REQ  per-requester write enable.
- addr_i  in  NUM_REQ x 32  per-requester address.
- wdata_i  in  NUM_REQ x 32  per-requester write data.
- gnt_o  out  NUM_REQ  one-hot acceptance pulse.
- rvalid_o  out  NUM_REQ  one-hot completion pulse.
- rdata_o  out  32  read data, shared by all requesters.
- err_o  out  1  error flag, valid with rvalid_o.
- uart_addr_o  out  32  address to the UART.
- uart_wdata_o  out  8  write byte to the UART.
- uart_read_req_o  out  1  UART read request (level).
- uart_read_resp_i  in  1  UART read response pulse.
- uart_write_req_o  out  1  UART write request (level).
- uart_write_resp_i  in  1  UART write response pulse.
- uart_rdata_i  in  32  UART read data.

Function
REQ-005 A requester SHALL hold req_i, we_i, addr_i and wdata_i stable from assertion until its gnt_o pulse.
REQ-006 The state machine SHALL have three states, IDLE, ISSUE and RESP, and SHALL leave reset in IDLE.
REQ-007 In IDLE with any req_i set, the arbiter SHALL assert gnt_o for the same cycle to exactly one requester, chosen round-robin starting at (last_owner+1) mod NUM_REQ.
REQ-008 On a grant, the arbiter SHALL latch the owner index, we, addr and wdata[7:0].
REQ-009 On a grant with a legal access, the next state SHALL be ISSUE; legal accesses are a write to WRITE_ADDRESS or a read from READ_ADDRESS.
REQ-010 On a grant with any other access, the arbiter SHALL go directly to RESP with err set and SHALL issue no UART request.
REQ-011 In ISSUE, exactly one of uart_write_req_o or uart_read_req_o SHALL be held high continuously, with uart_addr_o and uart_wdata_o equal to the latched values.
REQ-012 The UART request SHALL drop in the cycle after the matching response is sampled; the response of the opposite type SHALL be ignored.
REQ-013 On a response in ISSUE, the arbiter SHALL capture uart_rdata_i (reads) or 0 (writes), clear err, and go to RESP.
REQ-014 A cycle counter SHALL run in ISSUE; when it reaches TIMEOUT_CYCLES-1 with no response, the arbiter SHALL drop the request, set err, set rdata to 0 and go to RESP.
REQ-015 A response in the same cycle as counter expiry SHALL win, with err=0.
REQ-016 RESP SHALL last exactly one cycle: rvalid_o[owner]=1, rdata_o and err_o valid, last_owner updated to owner, next state IDLE.
REQ-017 No grant SHALL be issued in ISSUE or RESP; at most one transaction SHALL be outstanding.
REQ-018 Latency SHALL be: grant at cycle N, UART request from N+1, response at M, rvalid_o at M+1, next grant earliest at M+2.
REQ-019 rdata_o and err_o SHALL hold their values outside RESP; consumers sample them only with rvalid_o.

Reset
REQ-020 Asserting rst_ni low SHALL asynchronously force state IDLE, last_owner to NUM_REQ-1 (so requester 0 has priority first), counter to 0, and all outputs to 0.
REQ-021 Reset in the middle of a transaction SHALL abandon it with no rvalid_o pulse; the UART request SHALL be low immediately.

Structure
REQ-022 Package uart_arb_pkg SHALL hold the state enum type and the default WRITE_ADDRESS/READ_ADDRESS constants.
REQ-023 The round-robin picker SHALL be the sub-module uart_arb_rr: a combinational block taking the req vector and last_owner and producing a one-hot grant plus an index.

Verification
REQ-024 The bench SHALL cover the following directed scenarios:
- Requester 0 writes 0x41 to 0x10000000; write_resp arrives 5 cycles after the request -> gnt_o=01, uart_write_req_o high for 5 cycles with uart_wdata_o=0x41, rvalid_o=01 and err_o=0 one cycle later.
- Both requesters assert writes continuously from reset -> grants alternate 01, 10, 01, 10.
- Requester 1 reads 0x10000004 and the UART returns 0x000000AB -> rvalid_o=10, rdata_o=0xAB, err_o=0.
- Requester 0 writes 0x10000008 -> no UART request, rvalid_o=01 one cycle after gnt_o, err_o=1.
- TIMEOUT_CYCLES=16 and the UART never responds -> request drops after 16 cycles, rvalid_o with err_o=1 and rdata_o=0; a response arriving exactly in cycle 16 gives err_o=0.
- rst_ni pulsed low mid-ISSUE -> uart_write_req_o falls immediately, no rvalid_o, and the next grant goes to requester 0.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and address defaults for the UART request arbiter.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } arb_state_e;

    localparam logic [31:0] DEF_WRITE_ADDRESS = 32'h1000_0000;
    localparam logic [31:0] DEF_READ_ADDRESS  = 32'h1000_0004;

    // Only a write to the TX register or a read from the RX register reaches the UART.
    function automatic logic is_legal(input logic we, input logic [31:0] addr,
                                      input logic [31:0] wr_addr, input logic [31:0] rd_addr);
        return we ? (addr == wr_addr) : (addr == rd_addr);
    endfunction

endpackage

// File: rtl/uart_arb_rr.sv
// Round-robin picker: first requester after last_owner (wrapping) wins.
module uart_arb_rr #(
    parameter int NUM_REQ = 2,
    parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last_owner,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      idx
);

    logic found_s;
    int   sum_s;
    int   cand_s;

    // Scan from last_owner+1 so the previous owner is considered last.
    always_comb begin
        gnt     = {NUM_REQ{1'b0}};
        idx     = {IW{1'b0}};
        found_s = 1'b0;
        sum_s   = 0;
        cand_s  = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            sum_s  = int'(last_owner) + i;
            cand_s = (sum_s >= NUM_REQ) ? (sum_s - NUM_REQ) : sum_s;
            if (!found_s && req[cand_s[IW-1:0]]) begin
                found_s              = 1'b1;
                gnt[cand_s[IW-1:0]]  = 1'b1;
                idx                  = cand_s[IW-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/uart_arbiter.sv
// Arbitrates NUM_REQ requesters onto one UART request/response port, one
// transaction at a time, rejecting illegal addresses and timing out silent UARTs.
module uart_arbiter
    import uart_arb_pkg::*;
#(
    parameter int          NUM_REQ        = 2,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] WRITE_ADDRESS  = DEF_WRITE_ADDRESS,
    parameter logic [31:0] READ_ADDRESS   = DEF_READ_ADDRESS
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [NUM_REQ-1:0]       we_i,
    input  logic [NUM_REQ-1:0][31:0] addr_i,
    input  logic [NUM_REQ-1:0][31:0] wdata_i,
    output logic [NUM_REQ-1:0]       gnt_o,
    output logic [NUM_REQ-1:0]       rvalid_o,
    output logic [31:0]              rdata_o,
    output logic                     err_o,
    output logic [31:0]              uart_addr_o,
    output logic [7:0]               uart_wdata_o,
    output logic                     uart_read_req_o,
    input  logic                     uart_read_resp_i,
    output logic                     uart_write_req_o,
    input  logic                     uart_write_resp_i,
    input  logic [31:0]              uart_rdata_i
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    arb_state_e         state_r, next_state_s;
    logic [NUM_REQ-1:0] rr_gnt_s;
    logic [IW-1:0]      rr_idx_s;
    logic               any_req_s, legal_s, resp_s, expire_s;
    logic [NUM_REQ-1:0] owner_oh_s;

    logic [IW-1:0]      owner_r, last_owner_r;
    logic               we_r, err_r, wreq_r, rreq_r;
    logic [31:0]        addr_r, rdata_r;
    logic [7:0]         wdata_r;
    logic [CW-1:0]      cnt_r;
    logic [NUM_REQ-1:0] rvalid_r;
    logic               unused_wdata_s;

    uart_arb_rr #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr (
        .req        (req_i),
        .last_owner (last_owner_r),
        .gnt        (rr_gnt_s),
        .idx        (rr_idx_s)
    );

    assign any_req_s      = |req_i;
    assign legal_s        = is_legal(we_i[rr_idx_s], addr_i[rr_idx_s], WRITE_ADDRESS, READ_ADDRESS);
    assign resp_s         = we_r ? uart_write_resp_i : uart_read_resp_i;
    assign expire_s       = (cnt_r == CW'(TIMEOUT_CYCLES - 1));
    assign owner_oh_s     = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_r;
    assign unused_wdata_s = ^wdata_i;

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; a response on the expiry cycle still counts as a response.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    next_state_s = legal_s ? ST_ISSUE : ST_RESP;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (resp_s || expire_s) begin
                    next_state_s = ST_RESP;
                end else begin
                    next_state_s = ST_ISSUE;
                end
            end
            ST_RESP: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Grant is only offered while idle, in the same cycle as the request.
    always_comb begin
        if (state_r == ST_IDLE) begin
            gnt_o = rr_gnt_s;
        end else begin
            gnt_o = {NUM_REQ{1'b0}};
        end
    end

    // Transaction datapath: latch on grant, drive UART, capture result.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_r      <= {IW{1'b0}};
            last_owner_r <= IW'(NUM_REQ - 1);
            we_r         <= 1'b0;
            addr_r       <= 32'h0000_0000;
            wdata_r      <= 8'h00;
            cnt_r        <= {CW{1'b0}};
            rdata_r      <= 32'h0000_0000;
            err_r        <= 1'b0;
            rvalid_r     <= {NUM_REQ{1'b0}};
            wreq_r       <= 1'b0;
            rreq_r       <= 1'b0;
        end else begin
            rvalid_r <= {NUM_REQ{1'b0}};
            case (state_r)
                ST_IDLE: begin
                    if (any_req_s) begin
                        owner_r <= rr_idx_s;
                        we_r    <= we_i[rr_idx_s];
                        addr_r  <= addr_i[rr_idx_s];
                        wdata_r <= wdata_i[rr_idx_s][7:0];
                        cnt_r   <= {CW{1'b0}};
                        if (legal_s) begin
                            wreq_r <= we_i[rr_idx_s];
                            rreq_r <= ~we_i[rr_idx_s];
                        end else begin
                            err_r    <= 1'b1;
                            rdata_r  <= 32'h0000_0000;
                            rvalid_r <= rr_gnt_s;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (resp_s) begin
                        wreq_r   <= 1'b0;
                        rreq_r   <= 1'b0;
                        err_r    <= 1'b0;
                        rdata_r  <= we_r ? 32'h0000_0000 : uart_rdata_i;
                        rvalid_r <= owner_oh_s;
                    end else if (expire_s) begin
                        wreq_r   <= 1'b0;
                        rreq_r   <= 1'b0;
                        err_r    <= 1'b1;
                        rdata_r  <= 32'h0000_0000;
                        rvalid_r <= owner_oh_s;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_RESP: last_owner_r <= owner_r;
                default: last_owner_r <= last_owner_r;
            endcase
        end
    end

    assign rvalid_o         = rvalid_r;
    assign rdata_o          = rdata_r;
    assign err_o            = err_r;
    assign uart_addr_o      = addr_r;
    assign uart_wdata_o     = wdata_r;
    assign uart_write_req_o = wreq_r;
    assign uart_read_req_o  = rreq_r;

endmodule

// File: tb/tb_uart_arbiter.sv
// Directed scoreboard bench for uart_arbiter (2 requesters, 16-cycle timeout).
module tb_uart_arbiter;

    localparam int N  = 2;
    localparam int TO = 16;
    localparam logic [31:0] WA = 32'h1000_0000;
    localparam logic [31:0] RA = 32'h1000_0004;

    typedef logic [$clog2(N)-1:0] idx_t;
    typedef struct {
        logic [N-1:0] rv;
        logic [31:0]  rd;
        logic         err;
        bit           chk_rd;
    } rsp_t;

    logic               clk = 1'b0;
    logic               rst_ni;
    logic [N-1:0]       req_i, we_i, gnt_o, rvalid_o;
    logic [N-1:0][31:0] addr_i, wdata_i;
    logic [31:0]        rdata_o, uart_addr_o, uart_rdata_i;
    logic               err_o, uart_read_req_o, uart_read_resp_i, uart_write_req_o, uart_write_resp_i;
    logic [7:0]         uart_wdata_o;

    always #5 clk = ~clk;

    uart_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .err_o(err_o), .uart_addr_o(uart_addr_o), .uart_wdata_o(uart_wdata_o),
        .uart_read_req_o(uart_read_req_o), .uart_read_resp_i(uart_read_resp_i),
        .uart_write_req_o(uart_write_req_o), .uart_write_resp_i(uart_write_resp_i),
        .uart_rdata_i(uart_rdata_i)
    );

    int checks = 0;
    int errors = 0;
    logic [N-1:0] gnt_q[$];
    rsp_t         rsp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_txn(input idx_t r, input logic [31:0] rd, input logic err, input bit chk_rd);
        rsp_t e;
        e.rv     = N'(1'b1) << r;
        e.rd     = rd;
        e.err    = err;
        e.chk_rd = chk_rd;
        gnt_q.push_back(N'(1'b1) << r);
        rsp_q.push_back(e);
    endtask

    // Monitor: every grant / completion the DUT shows is checked against the queues.
    always @(negedge clk) begin : monitor
        logic [N-1:0] eg;
        rsp_t         er;
        if (rst_ni === 1'b1) begin
            if (gnt_o !== '0) begin
                if (gnt_q.size() == 0) chk("gnt_unexpected", 32'(gnt_o), 32'd0);
                else begin
                    eg = gnt_q.pop_front();
                    chk("gnt", 32'(gnt_o), 32'(eg));
                end
            end
            if (rvalid_o !== '0) begin
                if (rsp_q.size() == 0) chk("rvalid_unexpected", 32'(rvalid_o), 32'd0);
                else begin
                    er = rsp_q.pop_front();
                    chk("rvalid", 32'(rvalid_o), 32'(er.rv));
                    chk("err", 32'(err_o), 32'(er.err));
                    if (er.chk_rd) chk("rdata", rdata_o, er.rd);
                end
            end
        end
    end

    // UART model: counts request-high cycles, answers in the delay-th one (0 = never).
    task automatic serve(input bit is_write, input int delay, input logic [31:0] rd, input bit noise,
                         input logic [31:0] exp_addr, input logic [7:0] exp_wd, output int cnt);
        bit   done;
        logic lvl, opp;
        cnt  = 0;
        done = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            lvl = is_write ? uart_write_req_o : uart_read_req_o;
            opp = is_write ? uart_read_req_o : uart_write_req_o;
            chk("opposite_req_low", 32'(opp), 32'd0);
            if (lvl === 1'b1) begin
                cnt++;
                if (cnt == 1) begin
                    chk("uart_addr", uart_addr_o, exp_addr);
                    if (is_write) chk("uart_wdata", 32'(uart_wdata_o), 32'(exp_wd));
                end
                if (cnt == delay) begin
                    if (is_write) begin
                        uart_write_resp_i = 1'b1;
                        uart_rdata_i      = 32'hFFFF_FFFF;
                    end else begin
                        uart_read_resp_i = 1'b1;
                        uart_rdata_i     = rd;
                    end
                end else if (noise && cnt == 1) begin
                    if (is_write) uart_read_resp_i = 1'b1;
                    else uart_write_resp_i = 1'b1;
                end
                @(posedge clk); #1;
                uart_write_resp_i = 1'b0;
                uart_read_resp_i  = 1'b0;
            end else if (cnt > 0) begin
                done = 1'b1;
            end
        end
    endtask

    task automatic run_owner(input idx_t r, input logic [N-1:0] drop_mask, input bit is_write,
                             input bit legal, input int delay, input logic [31:0] rd, input bit noise,
                             input logic [31:0] exp_addr, input logic [7:0] exp_wd, input int exp_cnt);
        bit got;
        int cnt;
        got = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            if (gnt_o === (N'(1'b1) << r)) got = 1'b1;
        end
        chk("gnt_seen", 32'(got), 32'd1);
        @(posedge clk); #1;
        req_i = req_i & ~drop_mask;
        if (legal) begin
            serve(is_write, delay, rd, noise, exp_addr, exp_wd, cnt);
            chk("req_cycles", 32'(cnt), 32'(exp_cnt));
        end else begin
            @(negedge clk);
            chk("no_uart_req", 32'({uart_write_req_o, uart_read_req_o}), 32'd0);
        end
        chk("rvalid_timing", 32'(rvalid_o), 32'(N'(1'b1) << r));
    endtask

    task automatic do_txn(input idx_t r, input bit we, input logic [31:0] addr, input logic [31:0] wd,
                          input int delay, input logic [31:0] rd, input bit noise, input bit legal,
                          input logic [31:0] exp_rd, input logic exp_err, input bit chk_rd, input int exp_cnt);
        expect_txn(r, exp_rd, exp_err, chk_rd);
        @(posedge clk); #1;
        req_i[r]   = 1'b1;
        we_i[r]    = we;
        addr_i[r]  = addr;
        wdata_i[r] = wd;
        run_owner(r, N'(1'b1) << r, we, legal, delay, rd, noise, addr, wd[7:0], exp_cnt);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d checks", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bit got;
        rst_ni = 1'b0; req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0;
        uart_read_resp_i = 1'b0; uart_write_resp_i = 1'b0; uart_rdata_i = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_gnt", 32'(gnt_o), 32'd0);
        chk("rst_rvalid", 32'(rvalid_o), 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_uart_req", 32'({uart_write_req_o, uart_read_req_o}), 32'd0);
        chk("rst_uart_addr", uart_addr_o, 32'd0);
        chk("rst_uart_wdata", 32'(uart_wdata_o), 32'd0);

        // Both requesters write continuously from reset: grants alternate.
        for (int k = 0; k < 4; k++) expect_txn(idx_t'(k % 2), 32'h0, 1'b0, 1'b1);
        @(posedge clk); #1;
        req_i = 2'b11; we_i = 2'b11;
        addr_i[0] = WA; addr_i[1] = WA;
        wdata_i[0] = 32'h10; wdata_i[1] = 32'h20;
        rst_ni = 1'b1;
        for (int k = 0; k < 4; k++)
            run_owner(idx_t'(k % 2), (k == 3) ? 2'b11 : 2'b00, 1'b1, 1'b1, 2, 32'h0, 1'b0,
                      WA, (k % 2 == 1) ? 8'h20 : 8'h10, 2);

        // Write of 0x41 answered in the 5th request cycle.
        do_txn(1'b0, 1'b1, WA, 32'hDEAD_BE41, 5, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 5);
        // Read returning 0xAB, with a stray write response that must be ignored.
        do_txn(1'b1, 1'b0, RA, 32'h0, 3, 32'h0000_00AB, 1'b1, 1'b1, 32'h0000_00AB, 1'b0, 1'b1, 3);
        // Illegal accesses: write to 0x10000008, read from the write address.
        do_txn(1'b0, 1'b1, 32'h1000_0008, 32'h77, 0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 0);
        do_txn(1'b1, 1'b0, WA, 32'h0, 0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 0);
        // Silent UART: timeout after 16 request cycles.
        do_txn(1'b1, 1'b1, WA, 32'h5A, 0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1, TO);
        // Response in the 16th cycle beats the timeout.
        do_txn(1'b0, 1'b1, WA, 32'h5B, TO, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, TO);

        // Reset mid-ISSUE: request drops at once, no completion, requester 0 first afterwards.
        gnt_q.push_back(2'b01);
        @(posedge clk); #1;
        req_i[0] = 1'b1; we_i[0] = 1'b1; addr_i[0] = WA; wdata_i[0] = 32'h55;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (gnt_o === 2'b01) got = 1'b1;
        end
        chk("abort_gnt_seen", 32'(got), 32'd1);
        @(posedge clk); #1;
        req_i[0] = 1'b0;
        @(negedge clk);
        chk("abort_req_high", 32'(uart_write_req_o), 32'd1);
        @(negedge clk); #2;
        rst_ni = 1'b0;
        #1;
        chk("abort_req_drop", 32'(uart_write_req_o), 32'd0);
        chk("abort_no_rvalid", 32'(rvalid_o), 32'd0);
        @(posedge clk); #1;
        req_i = 2'b11; we_i = 2'b11;
        addr_i[0] = WA; addr_i[1] = WA;
        wdata_i[0] = 32'h61; wdata_i[1] = 32'h62;
        expect_txn(1'b0, 32'h0, 1'b0, 1'b1);
        expect_txn(1'b1, 32'h0, 1'b0, 1'b1);
        @(posedge clk); #1;
        rst_ni = 1'b1;
        run_owner(1'b0, 2'b01, 1'b1, 1'b1, 2, 32'h0, 1'b0, WA, 8'h61, 2);
        run_owner(1'b1, 2'b10, 1'b1, 1'b1, 2, 32'h0, 1'b0, WA, 8'h62, 2);

        repeat (4) @(negedge clk);
        chk("gnt_queue_drained", 32'(gnt_q.size()), 32'd0);
        chk("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
